// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a word-wide synchronous RAM (1-cycle read) and IO strobes, does
// sub-word load extension and read-modify-write sub-word stores. Optional: `MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemOrIoToReg_i,
    input  logic              IoRead_i,
    input  logic              IoWrite_i,
    input  logic              LoadUnsigned_i,
    input  logic [1:0]        ByteOrWord_i,
    input  logic [31:0]       ALUResult_i,
    input  logic [31:0]       rdata2_i,
    input  logic [4:0]        rd_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              io_rd_o,
    output logic              io_wr_o,
    output logic [31:0]       io_wdata_o,
    input  logic [31:0]       io_rdata_i,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              RegWrite_o,
    output logic              MemOrIoToReg_o,
    output logic [31:0]       ALUResult_o,
    output logic [31:0]       MemData_o,
    output logic [4:0]        rd_o
);

    typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_RD, RMW_WR} state_t;

    state_t      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_or_io_q;
    logic [31:0] alu_q;
    logic [4:0]  rd_q;

    logic [1:0]  lane;
    logic [4:0]  byte_sh, half_sh;
    logic        is_word, is_half, mis;
    logic        stall, mem_we, io_rd, io_wr;
    logic [31:0] mem_wdata, load_val, merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign lane    = ALUResult_i[1:0];
    assign byte_sh = {lane, 3'b000};
    assign half_sh = {lane[1], 4'b0000};
    assign is_word = ByteOrWord_i[1];
    assign is_half = (ByteOrWord_i == 2'b01);

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign mis        = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    assign misalign_d = (state_q == IDLE) && (MemRead_i || MemWrite_i) && mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign misalign_o = misalign_q;
`else
    // Without the trap, low address bits below the access size are simply ignored.
    assign mis        = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        ld_byte  = mem_rdata_i[byte_sh +: 8];
        ld_half  = mem_rdata_i[half_sh +: 16];
        load_val = mem_rdata_i;
        if (is_half)
            load_val = {{16{~LoadUnsigned_i & ld_half[15]}}, ld_half};
        else if (!is_word)
            load_val = {{24{~LoadUnsigned_i & ld_byte[7]}}, ld_byte};
    end

    always_comb begin
        merged = mem_rdata_i;
        if (is_half) merged[half_sh +: 16] = rdata2_i[15:0];
        else         merged[byte_sh +: 8]  = rdata2_i[7:0];
    end

    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        mem_data_d = mem_data_q;
        stall      = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = rdata2_i;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        case (state_q)
            IDLE: begin
                // Read has priority over a simultaneous write.
                if (MemRead_i) begin
                    if (mis) begin
                        mem_data_d = '0;
                    end else begin
                        stall   = 1'b1;
                        state_d = LD_WAIT;
                    end
                end else if (MemWrite_i) begin
                    if (!mis) begin
                        if (is_word) begin
                            mem_we = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = RMW_RD;
                        end
                    end
                end else begin
                    io_rd = IoRead_i;
                    io_wr = IoWrite_i;
                    if (IoRead_i) mem_data_d = io_rdata_i;
                end
            end
            LD_WAIT: begin
                mem_data_d = load_val;
                state_d    = IDLE;
            end
            RMW_RD: begin
                stall   = 1'b1;
                merge_d = merged;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                mem_we    = 1'b1;
                mem_wdata = merge_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign reg_write_d = stall ? 1'b0 : (RegWrite_i && (rd_i != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            merge_q     <= '0;
            mem_data_q  <= '0;
            reg_write_q <= 1'b0;
            mem_or_io_q <= 1'b0;
            alu_q       <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            merge_q     <= merge_d;
            mem_data_q  <= mem_data_d;
            reg_write_q <= reg_write_d;
            mem_or_io_q <= MemOrIoToReg_i;
            alu_q       <= ALUResult_i;
            rd_q        <= rd_i;
        end
    end

    // Strobes are gated by reset so nothing fires while the stage is held in reset.
    assign mem_addr_o     = ALUResult_i[ADDR_W+1:2];
    assign mem_we_o       = mem_we & rst_n;
    assign mem_wdata_o    = mem_wdata;
    assign io_rd_o        = io_rd & rst_n;
    assign io_wr_o        = io_wr & rst_n;
    assign io_wdata_o     = rdata2_i;
    assign stall_o        = stall & rst_n;
    assign RegWrite_o     = reg_write_q;
    assign MemOrIoToReg_o = mem_or_io_q;
    assign ALUResult_o    = alu_q;
    assign MemData_o      = mem_data_q;
    assign rd_o           = rd_q;

endmodule
